// File: rtl/imem_sync_loader.sv
// ============================================================================
// imem_sync_loader
// ----------------------------------------------------------------------------
// Synchronous-read instruction memory for the RISC-Duo fetch stage.
//
// After reset the block sits in BOOT. In BOOT a host or debugger streams the
// program image in through the valid/ready load port. The beat that carries
// load_last moves the block to RUN, and fetches are then served with a
// one-cycle registered read. A fetch whose word index is beyond DEPTH returns
// NOP_VAL and raises instr_err. Such a fetch never touches the array.
//
// Optional feature (compile-time macro):
//   IMEM_WR_FWD_EN  defined   -> In RUN, fetch_ready is always 1. A fetch and
//                                a load to the same in-range word in the same
//                                cycle return the incoming load_data
//                                (write-first).
//                   undefined -> In RUN, a load beat takes priority and stalls
//                                fetch for that cycle (fetch_ready = ~load_valid).
//
// Parameters:
//   DATA_W   instruction word width in bits
//   DEPTH    number of words (need not be a power of two)
//   ADDR_W   word-index width, derived from DEPTH (do not override)
//   NOP_VAL  word returned for an out-of-range fetch
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset (control state only)
//   fetch_req    in   fetch request this cycle
//   fetch_addr   in   word index to fetch
//   fetch_ready  out  fetch accepted when fetch_req & fetch_ready
//   instr_valid  out  one-cycle pulse after each accepted fetch
//   instruction  out  fetched word, held until the next accepted fetch
//   instr_err    out  the fetch that produced instruction was out of range
//   load_valid   in   load beat offered
//   load_addr    in   word index to write
//   load_data    in   word to write
//   load_last    in   final beat of the boot image (only used in BOOT)
//   load_ready   out  load beat accepted when load_valid & load_ready
//   boot_done    out  high while in RUN
//   boot_words   out  beats accepted in BOOT, saturating at DEPTH
// ============================================================================
module imem_sync_loader #(
  parameter int                DATA_W  = 32,
  parameter int                DEPTH   = 512,
  parameter int                ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter logic [DATA_W-1:0] NOP_VAL = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_err,

  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,

  output logic              boot_done,
  output logic [ADDR_W:0]   boot_words
);

  // DEPTH is widened by one bit. This lets an address compare against it
  // without truncation when DEPTH is an exact power of two.
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t next_state;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              load_fire;
  logic              fetch_fire;
  logic              fetch_in_range;
  logic              load_in_range;
  logic [DATA_W-1:0] read_word;

  // ------------------------------------------------------------------
  // Handshake qualifiers and range checks
  // ------------------------------------------------------------------
  assign load_fire      = load_valid & load_ready;
  assign fetch_fire     = fetch_req & fetch_ready;
  assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_CNT);
  assign load_in_range  = ({1'b0, load_addr} < DEPTH_CNT);

  // ------------------------------------------------------------------
  // State register. Reset always returns to BOOT, so the image must be
  // reloaded (or at least terminated with a load_last beat) before
  // fetch opens again.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= next_state;
    end
  end

  // ------------------------------------------------------------------
  // Next-state and handshake outputs.
  // load_ready is 1 in both states. The BOOT exit therefore keys off
  // load_valid directly, which keeps this block free of a feedback path
  // through its own load_ready output.
  // ------------------------------------------------------------------
  always_comb begin
    next_state  = state;
    fetch_ready = 1'b0;
    load_ready  = 1'b1;
    boot_done   = 1'b0;

    case (state)
      BOOT: begin
        if (load_valid && load_last) begin
          next_state = RUN;
        end
      end

      RUN: begin
        boot_done = 1'b1;
`ifdef IMEM_WR_FWD_EN
        fetch_ready = 1'b1;
`else
        fetch_ready = ~load_valid;
`endif
      end

      default: begin
        next_state = BOOT;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Storage array. It has no reset: the program image survives a
  // control reset. Out-of-range beats are accepted but dropped.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (load_fire && load_in_range) begin
      mem[load_addr] <= load_data;
    end
  end

  // ------------------------------------------------------------------
  // Read-data selection for an accepted fetch. An out-of-range index
  // yields NOP_VAL without indexing the array. With forwarding enabled,
  // a same-cycle write to the same word wins over the stale array
  // contents. Writes to a different word leave the old data visible.
  // ------------------------------------------------------------------
`ifdef IMEM_WR_FWD_EN
  logic fwd_hit;
  assign fwd_hit = load_fire & (load_addr == fetch_addr);
`endif

  always_comb begin
    read_word = NOP_VAL;
    if (fetch_in_range) begin
`ifdef IMEM_WR_FWD_EN
      if (fwd_hit) begin
        read_word = load_data;
      end else begin
        read_word = mem[fetch_addr];
      end
`else
      read_word = mem[fetch_addr];
`endif
    end
  end

  // ------------------------------------------------------------------
  // Registered read port. instr_valid pulses for exactly one cycle per
  // accepted fetch. instruction and instr_err hold their last values
  // until the next accepted fetch. Reset discards any fetch in flight.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_valid <= 1'b0;
      instruction <= NOP_VAL;
      instr_err   <= 1'b0;
    end else begin
      instr_valid <= fetch_fire;
      if (fetch_fire) begin
        instruction <= read_word;
        instr_err   <= ~fetch_in_range;
      end
    end
  end

  // ------------------------------------------------------------------
  // Boot beat counter. Every beat accepted in BOOT is counted, including
  // beats that are dropped for being out of range. The count stops at
  // DEPTH so that an oversized image cannot wrap it back to a small value.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      boot_words <= '0;
    end else if ((state == BOOT) && load_fire && (boot_words != DEPTH_CNT)) begin
      boot_words <= boot_words + (ADDR_W + 1)'(1);
    end
  end

endmodule
